ntt_block_radix2_pipelined: RTL and testbench

NTT_BLOCK_RADIX2_PIPELINED -- requirements
Module: ntt_block_radix2_pipelined

---
 rtl/ntt_block_radix2_pipelined.sv | 160 ++++++++++++++++
 tb/tb_ntt_block_radix2_pipelined.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_block_radix2_pipelined.sv
// Fully pipelined radix-2 DIT NTT/iNTT over Z_Q, one frame per clock, NTT_OUT_REG_EN adds an output register.
// Ports: clk, reset (async low), data_valid_in, iNTT_mode, Data_in[N] -> Data_out[N], data_valid_out, mode_out.
module ntt_block_radix2_pipelined #(
  parameter int W = 100,
  parameter int N = 8,
  parameter logic [W-1:0] Modulus_Q = W'(64'd2147483777),
  parameter logic [W-1:0] OMEGA     = W'(64'd1061363846),
  parameter logic [W-1:0] OMEGA_INV = W'(64'd1237364089)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         data_valid_in,
  input  logic         iNTT_mode,
  input  logic [W-1:0] Data_in [0:N-1],
  output logic [W-1:0] Data_out [0:N-1],
  output logic         data_valid_out,
  output logic         mode_out
);

  localparam int S = $clog2(N);
  localparam logic [2*W-1:0] QW = {{W{1'b0}}, Modulus_Q};
  localparam logic [W:0]     QX = {1'b0, Modulus_Q};

  function automatic logic [W-1:0] mul_mod(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return W'(({{W{1'b0}}, a} * {{W{1'b0}}, b}) % QW);
  endfunction

  function automatic logic [W-1:0] add_mod(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QX) ? W'(s - QX) : W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0] s;
    s = {1'b0, a} + QX - {1'b0, b};
    return (s >= QX) ? W'(s - QX) : W'(s);
  endfunction

  function automatic logic [W-1:0] pow_mod(
    input logic [W-1:0] b,
    input int           e
  );
    logic [W-1:0] r;
    logic [W-1:0] bb;
    r  = W'(1);
    bb = b % Modulus_Q;
    for (int i = 0; i < e; i++)
      r = mul_mod(r, bb);
    return r;
  endfunction

  function automatic int bitrev(input int x);
    int r;
    r = 0;
    for (int b = 0; b < S; b++)
      if (x[b]) r = r | (1 << (S - 1 - b));
    return r;
  endfunction

  // pipe[0] holds the reduced, bit-reversed capture; pipe[s+1] is stage s
  logic [W-1:0]     pipe [0:S][0:N-1];
  logic [S:0]       pipe_v;
  logic [S:0]       pipe_m;
  logic [S*N*W-1:0] bfly;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int H = 1 << s;
    localparam int M = 2 * H;
    for (genvar g = 0; g < N; g = g + M) begin : g_grp
      for (genvar j = 0; j < H; j++) begin : g_bf
        localparam int LO = g + j;
        localparam int HI = g + j + H;
        localparam logic [W-1:0] WF =
          pow_mod(OMEGA, j * (N / M));
        localparam logic [W-1:0] WI =
          pow_mod(OMEGA_INV, j * (N / M));
        logic [W-1:0] t;
        assign t = mul_mod(pipe[s][HI],
                           pipe_m[s] ? WI : WF);
        assign bfly[(s*N+LO)*W +: W] =
          add_mod(pipe[s][LO], t);
        assign bfly[(s*N+HI)*W +: W] =
          sub_mod(pipe[s][LO], t);
      end
    end
  end

  // data/mode registers load only with a valid frame so the
  // output side holds its last frame across bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_v <= '0;
      pipe_m <= '0;
      for (int s = 0; s <= S; s++)
        for (int i = 0; i < N; i++)
          pipe[s][i] <= '0;
    end else begin
      pipe_v <= {pipe_v[S-1:0], data_valid_in};
      if (data_valid_in) begin
        pipe_m[0] <= iNTT_mode;
        for (int i = 0; i < N; i++)
          pipe[0][i] <= Data_in[bitrev(i)] % Modulus_Q;
      end
      for (int s = 0; s < S; s++) begin
        if (pipe_v[s]) begin
          pipe_m[s+1] <= pipe_m[s];
          for (int i = 0; i < N; i++)
            pipe[s+1][i] <= bfly[(s*N+i)*W +: W];
        end
      end
    end
  end

`ifdef NTT_OUT_REG_EN
  logic [W-1:0] out_q [0:N-1];
  logic         out_v;
  logic         out_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v <= 1'b0;
      out_m <= 1'b0;
      for (int i = 0; i < N; i++)
        out_q[i] <= '0;
    end else begin
      out_v <= pipe_v[S];
      if (pipe_v[S]) begin
        out_m <= pipe_m[S];
        for (int i = 0; i < N; i++)
          out_q[i] <= pipe[S][i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      Data_out[i] = out_q[i];
  end
  assign data_valid_out = out_v;
  assign mode_out       = out_m;
`else
  always_comb begin
    for (int i = 0; i < N; i++)
      Data_out[i] = pipe[S][i];
  end
  assign data_valid_out = pipe_v[S];
  assign mode_out       = pipe_m[S];
`endif

endmodule

// File: tb/tb_ntt_block_radix2_pipelined.sv
// Scoreboard bench for ntt_block_radix2_pipelined (W=100, N=8).
// Driver queues expected frames; negedge monitor pops and compares.
module tb_ntt_block_radix2_pipelined;
  localparam int W = 100;
  localparam int N = 8;
`ifdef NTT_OUT_REG_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif
  localparam logic [127:0] Q    = 128'd2147483777;
  localparam logic [127:0] OM   = 128'd1061363846;
  localparam logic [127:0] OMI  = 128'd1237364089;
  localparam logic [127:0] PSI  = 128'd1323801281;
  localparam logic [127:0] NINV = 128'd1879048305;
  localparam logic [127:0] PSII = 128'd2145878094;

  typedef logic [N*W-1:0] fr_t;
  typedef struct packed {
    fr_t         d;
    logic        m;
    logic [31:0] cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vin;
  logic         mode;
  logic [W-1:0] din  [0:N-1];
  logic [W-1:0] dout [0:N-1];
  logic         vout;
  logic         mout;

  ntt_block_radix2_pipelined dut (
    .clk(clk),
    .reset(rst_n),
    .data_valid_in(vin),
    .iNTT_mode(mode),
    .Data_in(din),
    .Data_out(dout),
    .data_valid_out(vout),
    .mode_out(mout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  fr_t  got_q[$];

  function automatic logic [127:0] mm(input logic [127:0] a,
                                      input logic [127:0] b);
    return ((a % Q) * (b % Q)) % Q;
  endfunction

  function automatic logic [127:0] pw(input logic [127:0] b,
                                      input int e);
    logic [127:0] r;
    r = 1;
    for (int i = 0; i < e; i++) r = mm(r, b);
    return r;
  endfunction

  function automatic logic [W-1:0] el(input fr_t f, input int i);
    return f[i*W +: W];
  endfunction

  // direct O(N^2) transform sum
  function automatic fr_t ref_ntt(input fr_t x, input logic inv);
    fr_t          r;
    logic [127:0] acc;
    logic [127:0] w;
    w = inv ? OMI : OM;
    r = '0;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int j = 0; j < N; j++)
        acc = (acc + mm(el(x, j), pw(w, (j * k) % N))) % Q;
      r[k*W +: W] = W'(acc);
    end
    return r;
  endfunction

  function automatic fr_t fr(
    input logic [W-1:0] a0, input logic [W-1:0] a1,
    input logic [W-1:0] a2, input logic [W-1:0] a3,
    input logic [W-1:0] a4, input logic [W-1:0] a5,
    input logic [W-1:0] a6, input logic [W-1:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exv);
    end
  endtask

  task automatic check_fr(input string nm, input fr_t act,
                          input fr_t exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      for (int i = 0; i < N; i++) begin
        if (el(act, i) !== el(exv, i)) begin
          $display("FAIL %s: elem %0d got %0d expected %0d",
                   nm, i, el(act, i), el(exv, i));
          break;
        end
      end
    end
  endtask

  // monitor
  fr_t  cur;
  fr_t  last_d;
  logic last_m;
  exp_t e;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) cur[i*W +: W] = dout[i];
    if (!rst_n) begin
      last_d = '0;
      last_m = 1'b0;
    end else if (vout) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: valid at cycle %0d, none pending",
                 cyc);
      end else begin
        e = exp_q.pop_front();
        check_fr("frame_data", cur, e.d);
        check("frame_mode", mout, e.m);
        check("frame_latency", cyc, e.cyc);
      end
      got_q.push_back(cur);
      last_d = cur;
      last_m = mout;
    end else begin
      check_fr("hold_data", cur, last_d);
      check("hold_mode", mout, last_m);
    end
  end

  task automatic send(input fr_t x, input logic m,
                      input fr_t ex, input bit expect_out);
    @(posedge clk);
    #1;
    vin  = 1'b1;
    mode = m;
    for (int i = 0; i < N; i++) din[i] = el(x, i);
    if (expect_out)
      exp_q.push_back('{d: ex, m: m, cyc: 32'(cyc + 1 + L)});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic drain();
    int t;
    idle();
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d frames pending, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  fr_t          x, y, p, r, z;
  fr_t          one, imp, sh;
  fr_t          ta, tb, fa, fb;
  logic [127:0] ck;
  longint       sc;

  initial begin
    rst_n = 1'b0;
    vin   = 1'b0;
    mode  = 1'b0;
    for (int i = 0; i < N; i++) din[i] = '0;
    z = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) cur[i*W +: W] = dout[i];
    check("reset_valid", vout, 0);
    check("reset_mode", mout, 0);
    check_fr("reset_data", cur, z);
    rst_n = 1'b1;

    // impulse / constant / shifted impulse, back to back
    imp = fr(1, 0, 0, 0, 0, 0, 0, 0);
    one = fr(1, 1, 1, 1, 1, 1, 1, 1);
    sh  = fr(0, 1, 0, 0, 0, 0, 0, 0);
    got_q.delete();
    send(imp, 1'b0, one, 1);
    send(one, 1'b0, fr(8, 0, 0, 0, 0, 0, 0, 0), 1);
    send(one, 1'b1, fr(8, 0, 0, 0, 0, 0, 0, 0), 1);
    send(sh, 1'b0, ref_ntt(sh, 1'b0), 1);
    send(sh, 1'b1, ref_ntt(sh, 1'b1), 1);
    drain();
    check("burst_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("shift_fwd_e0", el(got_q[3], 0), 1);
      check("shift_fwd_e1", el(got_q[3], 1), OM);
      check("shift_inv_e1", el(got_q[4], 1), OMI);
    end
    repeat (3) @(posedge clk);

    // inputs at and beyond Q are reduced on capture
    x = fr(W'(Q), W'(Q + 5), {W{1'b1}}, W'(Q - 1),
           W'(Q - 1), 0, W'(1) << (W - 1), 12345);
    send(x, 1'b0, ref_ntt(x, 1'b0), 1);
    drain();

    // round trip: forward then inverse gives 8*x
    x = fr(3, 1, 4, 1, 5, 9, 2, 6);
    got_q.delete();
    send(x, 1'b0, ref_ntt(x, 1'b0), 1);
    drain();
    if (got_q.size() == 1) begin
      y = got_q[0];
      got_q.delete();
      send(y, 1'b1, fr(24, 8, 32, 8, 40, 72, 16, 48), 1);
      drain();
    end else begin
      check("roundtrip_count", got_q.size(), 1);
    end

    // negacyclic product of [1..8] with itself
    for (int i = 0; i < N; i++)
      ta[i*W +: W] = W'(mm(i + 1, pw(PSI, i)));
    tb = ta;
    got_q.delete();
    send(ta, 1'b0, ref_ntt(ta, 1'b0), 1);
    send(tb, 1'b0, ref_ntt(tb, 1'b0), 1);
    drain();
    check("nega_fwd_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      fa = got_q[0];
      fb = got_q[1];
      for (int i = 0; i < N; i++)
        p[i*W +: W] = W'(mm(el(fa, i), el(fb, i)));
      got_q.delete();
      send(p, 1'b1, ref_ntt(p, 1'b1), 1);
      drain();
      if (got_q.size() == 1) begin
        r = got_q[0];
        for (int k = 0; k < N; k++) begin
          ck = mm(mm(el(r, k), NINV), pw(PSII, k));
          sc = 0;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              if (i + j == k) sc += (i + 1) * (j + 1);
              if (i + j == k + N) sc -= (i + 1) * (j + 1);
            end
          sc = sc % 64'sd2147483777;
          if (sc < 0) sc += 64'sd2147483777;
          check($sformatf("nega_c%0d", k), ck, 128'(sc));
          if (k == 0) check("nega_c0_const", ck, 2147483631);
        end
      end else begin
        check("nega_inv_count", got_q.size(), 1);
      end
    end

    // reset one cycle after a frame is sampled
    send(one, 1'b1, z, 0);
    idle();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    for (int i = 0; i < N; i++) cur[i*W +: W] = dout[i];
    check("midreset_valid", vout, 0);
    check("midreset_mode", mout, 0);
    check_fr("midreset_data", cur, z);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (L + 4) @(posedge clk);

    // recovery
    send(imp, 1'b0, one, 1);
    drain();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
